// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter feeding a registered 4:1 mux with a valid/ready output.
// Define MUX4_ARB_LOCK_EN to enable burst lock (a granted source may keep the path).
module mux4_rr_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] din,
  input  logic [3:0]          lock,
  output logic [3:0]          gnt,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_src,
  input  logic                out_ready
);

  logic [1:0]        ptr;
  logic [1:0]        rr_win;
  logic [1:0]        win;
  logic              can_load;
  logic              grant;
  logic [DATA_W-1:0] sel_data;

  assign can_load = ~out_valid | out_ready;
  assign grant    = rst_n & can_load & (|req);

  // Scan from the farthest slot back to ptr so the nearest requester wins.
  always_comb begin
    logic [1:0] idx;
    rr_win = ptr;
    idx    = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_win = idx;
    end
  end

`ifdef MUX4_ARB_LOCK_EN
  logic       lock_act;
  logic [1:0] lock_id;
  logic       lock_hit;

  assign lock_hit = lock_act & req[lock_id];
  assign win      = lock_hit ? lock_id : rr_win;

  // A stall leaves the lock untouched; it only lapses when the path could load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_act <= 1'b0;
      lock_id  <= 2'd0;
    end else if (grant) begin
      lock_act <= lock[win];
      lock_id  <= win;
    end else if (can_load && lock_act && !req[lock_id]) begin
      lock_act <= 1'b0;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^lock;
  assign win         = rr_win;
`endif

  always_comb begin
    case (win)
      2'd0:    sel_data = din[0*DATA_W +: DATA_W];
      2'd1:    sel_data = din[1*DATA_W +: DATA_W];
      2'd2:    sel_data = din[2*DATA_W +: DATA_W];
      default: sel_data = din[3*DATA_W +: DATA_W];
    endcase
  end

  assign gnt = grant ? (4'b0001 << win) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
    end else if (grant) begin
      ptr       <= win + 2'd1;
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= win;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized and directed bench for mux4_rr_arbiter against a behavioural model.
// Follows MUX4_ARB_LOCK_EN the same way the design does.
module tb_mux4_rr_arbiter;
  localparam int DATA_W = 8;

  logic                clk;
  logic                rst_n;
  logic [3:0]          req;
  logic [4*DATA_W-1:0] din;
  logic [3:0]          lock;
  logic [3:0]          gnt;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_src;
  logic                out_ready;

  int total = 0;
  int bad   = 0;

  // reference state
  int          m_ptr;
  bit          m_valid;
  logic [7:0]  m_data;
  int          m_src;
  bit          m_lact;
  int          m_lid;

  logic [3:0] g;

  mux4_rr_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .lock(lock),
    .gnt(gnt), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Winning source index for the current inputs, or -1 if nothing is granted.
  function automatic int model_winner();
    if (rst_n !== 1'b1) return -1;
    if (m_valid && !out_ready) return -1;
    if (req == 4'b0) return -1;
`ifdef MUX4_ARB_LOCK_EN
    if (m_lact && req[m_lid]) return m_lid;
`endif
    for (int k = 0; k < 4; k++)
      if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic model_edge(input int w);
    if (rst_n !== 1'b1) begin
      m_ptr = 0; m_valid = 0; m_data = 8'h00; m_src = 0; m_lact = 0; m_lid = 0;
    end else if (w >= 0) begin
      m_data  = din[w*DATA_W +: DATA_W];
      m_src   = w;
      m_valid = 1;
      m_ptr   = (w + 1) % 4;
      m_lact  = lock[w];
      m_lid   = w;
    end else begin
      if (m_valid && out_ready && req == 4'b0) m_valid = 0;
      if ((!m_valid || out_ready) && m_lact && !req[m_lid]) m_lact = 0;
    end
  endtask

  // One clock: check gnt before the edge, outputs after it; returns observed gnt.
  task automatic cycle(output logic [3:0] gobs);
    int w;
    logic [3:0] eg;
    #1;
    w  = model_winner();
    eg = (w < 0) ? 4'b0000 : (4'b0001 << w);
    check("gnt", {28'b0, gnt}, {28'b0, eg});
    gobs = gnt;
    @(posedge clk);
    model_edge(w);
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("out_data", {24'b0, out_data}, {24'b0, m_data});
    check("out_src", {30'b0, out_src}, m_src[31:0]);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(g);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'hF; lock = 4'h0; out_ready = 1'b1;
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    m_ptr = 0; m_valid = 0; m_data = 0; m_src = 0; m_lact = 0; m_lid = 0;
    @(negedge clk);

    // reset with requests pending
    for (int i = 0; i < 3; i++) begin
      cycle(g);
      check("rst_gnt", {28'b0, g}, 32'h0);
    end
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_data", {24'b0, out_data}, 32'h00);
    check("rst_src", {30'b0, out_src}, 32'h0);
    rst_n = 1'b1;

    // round robin at full rate
    for (int i = 0; i < 5; i++) begin
      cycle(g);
      check("rr_gnt", {28'b0, g}, 32'(4'b0001 << (i % 4)));
      check("rr_data", {24'b0, out_data}, 32'(8'h11 * ((i % 4) + 1)));
    end

    // backpressure after 0x22 is captured
    do_reset();
    cycle(g);
    cycle(g);
    check("bp_pre", {24'b0, out_data}, 32'h22);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(g);
      check("bp_gnt", {28'b0, g}, 32'h0);
      check("bp_hold", {24'b0, out_data}, 32'h22);
    end
    out_ready = 1'b1;
    cycle(g);
    check("bp_release", {28'b0, g}, 32'h4);
    check("bp_next", {24'b0, out_data}, 32'h33);

    // wrap: source 2 just granted, only 0 and 1 request
    req = 4'b0011;
    cycle(g);
    check("wrap0", {28'b0, g}, 32'h1);
    cycle(g);
    check("wrap1", {28'b0, g}, 32'h2);

    // burst lock sequence
    do_reset();
    req = 4'b0101; lock = 4'b0001;
`ifdef MUX4_ARB_LOCK_EN
    for (int i = 0; i < 3; i++) begin
      cycle(g);
      check("lock_hold", {28'b0, g}, 32'h1);
    end
    lock = 4'b0000;
    cycle(g);
    check("lock_last", {28'b0, g}, 32'h1);
    cycle(g);
    check("lock_after", {28'b0, g}, 32'h4);
`else
    cycle(g);
    check("nolock0", {28'b0, g}, 32'h1);
    cycle(g);
    check("nolock1", {28'b0, g}, 32'h4);
    cycle(g);
    check("nolock2", {28'b0, g}, 32'h1);
`endif
    lock = 4'b0000;

    // reset while stalled
    out_ready = 1'b0;
    cycle(g);
    check("mid_full", {31'b0, out_valid}, 32'h1);
    rst_n = 1'b0;
    cycle(g);
    check("mid_rst", {31'b0, out_valid}, 32'h0);
    rst_n = 1'b1; out_ready = 1'b1; req = 4'b1001;
    cycle(g);
    check("mid_gnt", {28'b0, g}, 32'h1);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      req       = 4'($urandom);
      din       = $urandom;
      lock      = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 60) != 0);
      cycle(g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
